// File: rtl/ram_block_writer_pkg.sv
// ram_block_writer_pkg: shared word width, block address width and FSM encoding
package ram_block_writer_pkg;
    localparam int WORD_W  = 16;
    localparam int BLOCK_W = 21;
    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CMD, S_DATA, S_DONE} state_t;
endpackage

// File: rtl/ram_block_writer_if.sv
// ram_block_writer_if: job control, input stream and RAMController cmd/data signals
interface ram_block_writer_if
    import ram_block_writer_pkg::*;
#(
    parameter int BlockWidth = BLOCK_W
);
    logic                  ctrl_start;
    logic [BlockWidth-1:0] ctrl_block;
    logic [BlockWidth-1:0] ctrl_blockCount;
    logic                  ctrl_busy;
    logic                  ctrl_done;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_W-1:0]     in_data;
    logic                  cmd_ready;
    logic                  cmd_trigger;
    logic [BlockWidth-1:0] cmd_block;
    logic                  cmd_write;
    logic                  data_ready;
    logic                  data_trigger;
    logic [WORD_W-1:0]     data_write;

    modport master (
        input  ctrl_start, ctrl_block, ctrl_blockCount, in_valid, in_data, cmd_ready, data_ready,
        output ctrl_busy, ctrl_done, in_ready, cmd_trigger, cmd_block, cmd_write, data_trigger, data_write
    );

    modport slave (
        output ctrl_start, ctrl_block, ctrl_blockCount, in_valid, in_data, cmd_ready, data_ready,
        input  ctrl_busy, ctrl_done, in_ready, cmd_trigger, cmd_block, cmd_write, data_trigger, data_write
    );
endinterface

// File: rtl/ram_block_fifo.sv
// ram_block_fifo: synchronous first-word-fall-through FIFO buffering stream words
module ram_block_fifo
    import ram_block_writer_pkg::*;
#(
    parameter int Width = WORD_W,
    parameter int Depth = 32
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic                   push,
    input  logic                   pop,
    input  logic [Width-1:0]       din,
    output logic [Width-1:0]       dout,
    output logic [$clog2(Depth):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PtrW = $clog2(Depth);

    logic [Width-1:0] r_mem [Depth];
    logic [PtrW-1:0]  r_wr;
    logic [PtrW-1:0]  r_rd;
    logic [PtrW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = r_count == (PtrW+1)'(Depth);
    assign empty  = r_count == '0;
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = r_mem[r_rd];
    assign count  = r_count;

    // storage has no reset: the head is don't-care while empty
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end

    // pointers wrap naturally because Depth is a power of two
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_count <= r_count + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/ram_block_writer.sv
// ram_block_writer: buffers a word stream and writes it to SDRAM as whole blocks
module ram_block_writer
    import ram_block_writer_pkg::*;
#(
    parameter int BlockWidth = BLOCK_W,
    parameter int BlockSize  = 16,
    parameter int FifoDepth  = 32
) (
    input logic                clk,
    input logic                rst_,
    ram_block_writer_if.master bus
);
    localparam int SizeLog = $clog2(BlockSize);
    localparam int CountW  = $clog2(FifoDepth) + 1;
    localparam int AccW    = BlockWidth + SizeLog + 1;
    localparam int BeatW   = SizeLog + 1;

    state_t                r_state;
    state_t                w_next;
    logic [BlockWidth-1:0] r_block;
    logic [BlockWidth-1:0] r_left;
    logic [BlockWidth-1:0] r_total;
    logic [AccW-1:0]       r_accepted;
    logic [AccW-1:0]       w_limit;
    logic [BeatW-1:0]      r_beats;
    logic [CountW-1:0]     w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_busy;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_end;

    assign w_busy  = r_state != S_IDLE;
    assign w_limit = (AccW'(r_total) + AccW'(1)) << SizeLog;
    assign w_push  = bus.in_valid && bus.in_ready;
    assign w_pop   = bus.data_trigger && bus.data_ready;
    assign w_end   = r_state == S_DATA && bus.cmd_ready;

    assign bus.ctrl_busy    = w_busy;
    assign bus.ctrl_done    = r_state == S_DONE;
    assign bus.in_ready     = w_busy && !w_full && r_accepted < w_limit;
    assign bus.cmd_trigger  = r_state == S_CMD;
    assign bus.cmd_block    = r_block;
    assign bus.cmd_write    = 1'b1;
    assign bus.data_trigger = r_state == S_DATA && !bus.cmd_ready && !w_empty;

    ram_block_fifo #(.Width(WORD_W), .Depth(FifoDepth)) u_fifo (
        .clk   (clk),
        .rst_  (rst_),
        .push  (w_push),
        .pop   (w_pop),
        .din   (bus.in_data),
        .dout  (bus.data_write),
        .count (w_count),
        .full  (w_full),
        .empty (w_empty)
    );

    // job sequencing: a command is only requested once a whole block is buffered
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = bus.ctrl_start ? S_FILL : S_IDLE;
            S_FILL:  w_next = w_count >= CountW'(BlockSize) ? S_CMD : S_FILL;
            S_CMD:   w_next = bus.cmd_ready ? S_DATA : S_CMD;
            S_DATA:  w_next = !bus.cmd_ready ? S_DATA : (r_left != '0 ? S_FILL : S_DONE);
            default: w_next = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    // job parameters, accepted-word count and per-block beat count
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            r_block    <= '0;
            r_left     <= '0;
            r_total    <= '0;
            r_accepted <= '0;
            r_beats    <= '0;
        end else begin
            if (w_push) r_accepted <= r_accepted + 1'b1;
            if (r_state == S_IDLE && bus.ctrl_start) begin
                r_block    <= bus.ctrl_block;
                r_left     <= bus.ctrl_blockCount;
                r_total    <= bus.ctrl_blockCount;
                r_accepted <= '0;
            end else if (w_end && r_left != '0) begin
                r_block <= r_block + 1'b1;
                r_left  <= r_left - 1'b1;
            end
            if (r_state == S_CMD) r_beats <= '0;
            else if (w_pop) r_beats <= r_beats + 1'b1;
        end
    end

    // the controller must have taken exactly one block before it reports idle
    a_block_len: assert property (@(posedge clk) disable iff (!rst_) w_end |-> r_beats == BeatW'(BlockSize));
endmodule

// File: tb/tb_ram_block_writer.sv
// tb_ram_block_writer: directed tests with a behavioural RAMController and stream source
module tb_ram_block_writer;
    logic clk = 1'b0;
    logic rst_ = 1'b0;
    always #5 clk = ~clk;

    ram_block_writer_if #(.BlockWidth(21)) bus ();

    ram_block_writer #(.BlockWidth(21), .BlockSize(16), .FifoDepth(32)) dut (
        .clk  (clk),
        .rst_ (rst_),
        .bus  (bus)
    );

    int checks = 0;
    int passes = 0;

    int src_total = 0;
    int src_sent  = 0;
    int src_gap   = 1;
    int src_phase = 0;
    int extra     = 0;
    bit src_hold  = 1'b0;

    int ram_gap  = 1;
    int m_state  = 0;
    int m_beats  = 0;
    int m_phase  = 0;
    int trig_err = 0;
    logic [20:0] cmd_q [$];
    logic [15:0] word_q [$];

    // stream source: word k of the whole run carries value k
    initial begin
        bit have;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        forever begin
            @(negedge clk);
            src_phase++;
            have = src_sent < src_total;
            bus.in_valid = (have && (src_phase % src_gap == 0)) || src_hold;
            bus.in_data  = have ? 16'(src_sent) : 16'hDEAD;
            #1;
            if (bus.in_valid && bus.in_ready) begin
                if (have) src_sent++;
                else extra++;
            end
        end
    end

    // RAMController model: accepts a command, takes 16 beats every ram_gap cycles, then goes idle
    initial begin
        bus.cmd_ready  = 1'b1;
        bus.data_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_) begin
                m_state = 0;
                bus.cmd_ready  = 1'b1;
                bus.data_ready = 1'b0;
            end else if (m_state == 0) begin
                if (bus.cmd_trigger) begin
                    cmd_q.push_back(bus.cmd_block);
                    m_state = 1;
                    m_beats = 0;
                    m_phase = 0;
                end
            end else if (m_state == 1) begin
                bus.cmd_ready = 1'b0;
                m_phase++;
                #1;
                if (m_phase % ram_gap == 0) begin
                    if (!bus.data_trigger) trig_err++;
                    bus.data_ready = 1'b1;
                    word_q.push_back(bus.data_write);
                    m_beats++;
                    if (m_beats == 16) m_state = 2;
                end else begin
                    bus.data_ready = 1'b0;
                end
            end else begin
                bus.data_ready = 1'b0;
                bus.cmd_ready  = 1'b1;
                m_state = 0;
            end
        end
    end

    function automatic int data_errs(int wbase, int base, int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (wbase + i >= word_q.size() || word_q[wbase+i] !== 16'(base + i)) e++;
        return e;
    endfunction

    task automatic start_job(input logic [20:0] blk, input logic [20:0] cnt);
        @(negedge clk);
        bus.ctrl_block      = blk;
        bus.ctrl_blockCount = cnt;
        bus.ctrl_start      = 1'b1;
        @(negedge clk);
        bus.ctrl_start = 1'b0;
    endtask

    task automatic wait_done(output int dones, output bit to);
        dones = 0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ctrl_done) dones++;
            if (!bus.ctrl_busy) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        bus.ctrl_start = 1'b0;
        bus.ctrl_block = '0;
        bus.ctrl_blockCount = '0;
        repeat (2) @(negedge clk);
        checks++; if (bus.ctrl_busy !== 1'b0) $display("FAIL reset ctrl_busy: got %b want 0", bus.ctrl_busy); else passes++;
        checks++; if (bus.ctrl_done !== 1'b0) $display("FAIL reset ctrl_done: got %b want 0", bus.ctrl_done); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset in_ready: got %b want 0", bus.in_ready); else passes++;
        checks++; if (bus.cmd_trigger !== 1'b0) $display("FAIL reset cmd_trigger: got %b want 0", bus.cmd_trigger); else passes++;
        checks++; if (bus.data_trigger !== 1'b0) $display("FAIL reset data_trigger: got %b want 0", bus.data_trigger); else passes++;
        checks++; if (bus.cmd_block !== 21'h0) $display("FAIL reset cmd_block: got %h want 0", bus.cmd_block); else passes++;
        checks++; if (bus.cmd_write !== 1'b1) $display("FAIL reset cmd_write: got %b want 1", bus.cmd_write); else passes++;
        @(posedge clk);
        #2 rst_ = 1'b1;
    endtask

    task automatic test_single_block;
        int base, cb, wb, dones;
        bit to;
        cb = cmd_q.size();
        wb = word_q.size();
        base = src_total;
        src_total += 16;
        start_job(21'h10, 21'h0);
        wait_done(dones, to);
        checks++; if (to !== 1'b0) $display("FAIL single timeout: busy still %b", bus.ctrl_busy); else passes++;
        checks++; if (dones !== 1) $display("FAIL single done pulses: got %0d want 1", dones); else passes++;
        checks++; if (cmd_q.size() - cb !== 1) $display("FAIL single cmd count: got %0d want 1", cmd_q.size() - cb); else passes++;
        checks++; if ((cmd_q.size() > cb ? cmd_q[cb] : 21'bx) !== 21'h10) $display("FAIL single cmd_block: got %h want 10", cmd_q.size() > cb ? cmd_q[cb] : 21'bx); else passes++;
        checks++; if (word_q.size() - wb !== 16) $display("FAIL single beats: got %0d want 16", word_q.size() - wb); else passes++;
        checks++; if (data_errs(wb, base, 16) !== 0) $display("FAIL single readback: %0d wrong words want 0", data_errs(wb, base, 16)); else passes++;
    endtask

    task automatic test_wrap_multi;
        int base, cb, wb, dones;
        bit to;
        logic [20:0] exp [4] = '{21'h1FFFFE, 21'h1FFFFF, 21'h000000, 21'h000001};
        cb = cmd_q.size();
        wb = word_q.size();
        base = src_total;
        src_total += 64;
        start_job(21'h1FFFFE, 21'd3);
        wait_done(dones, to);
        checks++; if (to !== 1'b0) $display("FAIL wrap timeout: busy still %b", bus.ctrl_busy); else passes++;
        checks++; if (dones !== 1) $display("FAIL wrap done pulses: got %0d want 1", dones); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ((cmd_q.size() > cb + i ? cmd_q[cb+i] : 21'bx) !== exp[i])
                $display("FAIL wrap cmd_block[%0d]: got %h want %h", i, cmd_q.size() > cb + i ? cmd_q[cb+i] : 21'bx, exp[i]);
            else passes++;
        end
        checks++; if (src_sent - base !== 64) $display("FAIL wrap accepted: got %0d want 64", src_sent - base); else passes++;
        checks++; if (data_errs(wb, base, 64) !== 0 || word_q.size() - wb !== 64) $display("FAIL wrap readback: %0d wrong of %0d beats want 0 of 64", data_errs(wb, base, 64), word_q.size() - wb); else passes++;
    endtask

    task automatic test_throttle;
        int base, wb, te, dones, first_acc;
        bit to;
        wb = word_q.size();
        te = trig_err;
        base = src_total;
        src_gap = 3;
        src_total += 16;
        start_job(21'h20, 21'h0);
        first_acc = -1;
        dones = 0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.cmd_trigger && first_acc < 0) first_acc = src_sent - base;
            if (bus.ctrl_done) dones++;
            if (!bus.ctrl_busy) begin
                to = 1'b0;
                break;
            end
        end
        src_gap = 1;
        checks++; if (to !== 1'b0 || dones !== 1) $display("FAIL throttle completion: timeout %b done pulses %0d want 0 and 1", to, dones); else passes++;
        checks++; if (first_acc !== 16) $display("FAIL throttle words before cmd: got %0d want 16", first_acc); else passes++;
        checks++; if (trig_err - te !== 0) $display("FAIL throttle data_trigger low on beat: got %0d want 0", trig_err - te); else passes++;
        checks++; if (data_errs(wb, base, 16) !== 0) $display("FAIL throttle readback: %0d wrong words want 0", data_errs(wb, base, 16)); else passes++;
    endtask

    task automatic test_backpressure;
        int base, cb, wb, dones, occ, max_occ;
        bit to;
        cb = cmd_q.size();
        wb = word_q.size();
        base = src_total;
        ram_gap = 4;
        src_total += 64;
        start_job(21'h30, 21'd3);
        max_occ = 0;
        dones = 0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            occ = (src_sent - base) - (word_q.size() - wb);
            if (occ > max_occ) max_occ = occ;
            if (bus.ctrl_done) dones++;
            if (!bus.ctrl_busy) begin
                to = 1'b0;
                break;
            end
        end
        ram_gap = 1;
        checks++; if (to !== 1'b0 || dones !== 1) $display("FAIL backpressure completion: timeout %b done pulses %0d want 0 and 1", to, dones); else passes++;
        checks++; if (max_occ !== 32) $display("FAIL backpressure peak fill: got %0d want 32", max_occ); else passes++;
        checks++; if ((cmd_q.size() > cb + 3 ? cmd_q[cb+3] : 21'bx) !== 21'h33) $display("FAIL backpressure last cmd_block: got %h want 33", cmd_q.size() > cb + 3 ? cmd_q[cb+3] : 21'bx); else passes++;
        checks++; if (data_errs(wb, base, 64) !== 0 || word_q.size() - wb !== 64) $display("FAIL backpressure readback: %0d wrong of %0d beats want 0 of 64", data_errs(wb, base, 64), word_q.size() - wb); else passes++;
    endtask

    task automatic test_start_while_busy;
        int base, cb, ex, dones, over;
        bit to;
        cb = cmd_q.size();
        ex = extra;
        base = src_total;
        src_total += 16;
        src_hold = 1'b1;
        start_job(21'h40, 21'h0);
        repeat (3) @(negedge clk);
        bus.ctrl_block = 21'h55;
        bus.ctrl_start = 1'b1;
        @(negedge clk);
        bus.ctrl_start = 1'b0;
        over = 0;
        dones = 0;
        to = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (bus.ctrl_busy && bus.in_ready && src_sent - base >= 16) over++;
            if (bus.ctrl_done) dones++;
            if (!bus.ctrl_busy) begin
                to = 1'b0;
                break;
            end
        end
        repeat (4) @(negedge clk);
        src_hold = 1'b0;
        checks++; if (to !== 1'b0 || dones !== 1) $display("FAIL busy-start completion: timeout %b done pulses %0d want 0 and 1", to, dones); else passes++;
        checks++; if (cmd_q.size() - cb !== 1 || cmd_q[cb] !== 21'h40) $display("FAIL busy-start commands: got %0d want 1 at 40", cmd_q.size() - cb); else passes++;
        checks++; if (over !== 0) $display("FAIL overrun in_ready: high %0d cycles after last word want 0", over); else passes++;
        checks++; if (extra - ex !== 0) $display("FAIL overrun words accepted: got %0d want 0", extra - ex); else passes++;
        checks++; if (bus.ctrl_busy !== 1'b0) $display("FAIL busy-start restart: ctrl_busy %b want 0", bus.ctrl_busy); else passes++;
    endtask

    task automatic test_reset_mid_data;
        int base, cb, wb, dones;
        bit to, seen;
        src_total += 16;
        start_job(21'h50, 21'h0);
        seen = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.data_trigger) begin
                seen = 1'b1;
                break;
            end
        end
        checks++; if (seen !== 1'b1) $display("FAIL midreset reached data: got %b want 1", seen); else passes++;
        #2 rst_ = 1'b0;
        #1;
        checks++; if (bus.ctrl_busy !== 1'b0) $display("FAIL midreset ctrl_busy: got %b want 0", bus.ctrl_busy); else passes++;
        checks++; if (bus.data_trigger !== 1'b0) $display("FAIL midreset data_trigger: got %b want 0", bus.data_trigger); else passes++;
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL midreset in_ready: got %b want 0", bus.in_ready); else passes++;
        checks++; if (bus.cmd_block !== 21'h0) $display("FAIL midreset cmd_block: got %h want 0", bus.cmd_block); else passes++;
        @(negedge clk);
        @(posedge clk);
        #2 rst_ = 1'b1;
        cb = cmd_q.size();
        wb = word_q.size();
        base = src_total;
        src_total += 16;
        start_job(21'h60, 21'h0);
        wait_done(dones, to);
        checks++; if (to !== 1'b0 || dones !== 1) $display("FAIL postreset completion: timeout %b done pulses %0d want 0 and 1", to, dones); else passes++;
        checks++; if (cmd_q.size() - cb !== 1 || cmd_q[cb] !== 21'h60) $display("FAIL postreset commands: got %0d want 1 at 60", cmd_q.size() - cb); else passes++;
        checks++; if (data_errs(wb, base, 16) !== 0) $display("FAIL postreset readback: %0d wrong words want 0", data_errs(wb, base, 16)); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_wrap_multi();
        test_throttle();
        test_backpressure();
        test_start_while_busy();
        test_reset_mid_data();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached with %0d/%0d checks passed", passes, checks);
        $fatal(1);
    end
endmodule
